// File: rtl/ddr3_bank_ctrl.sv
// ddr3_bank_ctrl: single-command-at-a-time DDR3 bank controller.
// Keeps an open-row table per bank and turns upstream BL8 requests into
// PREC/ACTV/READ/WRIT sequences, plus PREC-all/REFR on refresh requests.
// Optional feature macro: DDR3_BANK_CTRL_AUTOPRE_EN (closed-page policy;
// every READ/WRIT carries auto-precharge). Undefined = open-page policy.
module ddr3_bank_ctrl #(
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_COL_BITS = 10,
  parameter int ADDR_BITS    = DDR_ROW_BITS + 3 + DDR_COL_BITS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ctl_rdy_i,
  input  logic                    ctl_rfc_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_BITS-1:0]    req_addr_i,
  output logic                    request_o,
  output logic [3:0]              command_o,
  output logic                    autopre_o,
  input  logic                    accept_i,
  output logic [2:0]              bank_o,
  output logic [DDR_ROW_BITS-1:0] addr_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREC, ST_ACTV, ST_XFER, ST_PREA, ST_REFR
  } state_e;

  // {CS#,RAS#,CAS#,WE#}
  localparam logic [3:0] CMD_NOOP = 4'b0111;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_WRIT = 4'b0100;
  localparam logic [3:0] CMD_ACTV = 4'b0011;
  localparam logic [3:0] CMD_PREC = 4'b0010;
  localparam logic [3:0] CMD_REFR = 4'b0001;

  // Address bit that selects "all banks" on a precharge.
  localparam int A10 = 10;

`ifdef DDR3_BANK_CTRL_AUTOPRE_EN
  localparam logic AUTOPRE = 1'b1;
`else
  localparam logic AUTOPRE = 1'b0;
`endif

  state_e state_q, state_d;

  logic [7:0]              open_q, open_d;
  logic [DDR_ROW_BITS-1:0] row_q [8];

  logic                    req_write_q;
  logic [DDR_ROW_BITS-1:0] req_row_q;
  logic [2:0]              req_bank_q;
  logic [DDR_COL_BITS-1:0] req_col_q;

  // Request address fields, mapped {row, bank, col}.
  logic [DDR_ROW_BITS-1:0] in_row;
  logic [2:0]              in_bank;
  logic [DDR_COL_BITS-1:0] in_col;
  assign in_row  = req_addr_i[ADDR_BITS-1 -: DDR_ROW_BITS];
  assign in_bank = req_addr_i[DDR_COL_BITS +: 3];
  assign in_col  = req_addr_i[DDR_COL_BITS-1:0];

  logic capture;
  assign capture = (state_q == ST_IDLE) && ctl_rdy_i && !ctl_rfc_i && req_valid_i;

  // State register and open flags of the row table.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      open_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      open_q  <= open_d;
    end
  end

  // Captured request and row numbers of the table.
  // NOTE: no reset here; a row field is only read while its open bit is set,
  // and the captured request is only used outside ST_IDLE, so resetting the
  // open bits and the state is enough.
  always_ff @(posedge clock) begin
    if (capture) begin
      req_write_q <= req_write_i;
      req_row_q   <= in_row;
      req_bank_q  <= in_bank;
      req_col_q   <= in_col;
    end
    if (state_q == ST_ACTV && accept_i) begin
      row_q[req_bank_q] <= req_row_q;
    end
  end

  // Next state and open-flag updates.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d = state_q;
    open_d  = open_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctl_rdy_i) begin
          if (ctl_rfc_i) begin
            state_d = (|open_q) ? ST_PREA : ST_REFR;
          end else if (req_valid_i) begin
            if (!open_q[in_bank])              state_d = ST_ACTV;
            else if (row_q[in_bank] == in_row) state_d = ST_XFER;
            else                               state_d = ST_PREC;
          end
        end
      end
      ST_PREC: if (accept_i) begin
        open_d[req_bank_q] = 1'b0;
        state_d = ctl_rdy_i ? ST_ACTV : ST_IDLE;
      end
      ST_ACTV: if (accept_i) begin
        open_d[req_bank_q] = 1'b1;
        state_d = ctl_rdy_i ? ST_XFER : ST_IDLE;
      end
      ST_XFER: if (accept_i) begin
        if (AUTOPRE) open_d[req_bank_q] = 1'b0;
        state_d = ST_IDLE;
      end
      ST_PREA: if (accept_i) begin
        open_d  = '0;
        state_d = ctl_rdy_i ? ST_REFR : ST_IDLE;
      end
      ST_REFR: if (accept_i) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command outputs, a pure function of state and captured request so they
  // hold steady while a command waits for accept_i.
  always_comb begin
    request_o   = 1'b0;
    req_ready_o = 1'b0;
    command_o   = CMD_NOOP;
    autopre_o   = 1'b0;
    bank_o      = '0;
    addr_o      = '0;
    unique case (state_q)
      ST_PREC: begin
        request_o = 1'b1;
        command_o = CMD_PREC;
        bank_o    = req_bank_q;
      end
      ST_ACTV: begin
        request_o = 1'b1;
        command_o = CMD_ACTV;
        bank_o    = req_bank_q;
        addr_o    = req_row_q;
      end
      ST_XFER: begin
        request_o   = 1'b1;
        command_o   = req_write_q ? CMD_WRIT : CMD_READ;
        autopre_o   = AUTOPRE;
        bank_o      = req_bank_q;
        addr_o[DDR_COL_BITS-1:0] = req_col_q;
        req_ready_o = accept_i;
      end
      ST_PREA: begin
        request_o   = 1'b1;
        command_o   = CMD_PREC;
        addr_o[A10] = 1'b1;
      end
      ST_REFR: begin
        request_o = 1'b1;
        command_o = CMD_REFR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr3_bank_ctrl.sv
// Directed bench for ddr3_bank_ctrl: logs every accepted command and
// compares against hand-built expected command lists.
module tb_ddr3_bank_ctrl;

  localparam int RB = 13;
  localparam int CB = 10;
  localparam int AB = RB + 3 + CB;

  localparam logic [3:0] NOOP = 4'b0111;
  localparam logic [3:0] READ = 4'b0101;
  localparam logic [3:0] WRIT = 4'b0100;
  localparam logic [3:0] ACTV = 4'b0011;
  localparam logic [3:0] PREC = 4'b0010;
  localparam logic [3:0] REFR = 4'b0001;

`ifdef DDR3_BANK_CTRL_AUTOPRE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  logic          clock, reset_n;
  logic          ctl_rdy_i, ctl_rfc_i, req_valid_i, req_ready_o, req_write_i;
  logic [AB-1:0] req_addr_i;
  logic          request_o, autopre_o, accept_i;
  logic [3:0]    command_o;
  logic [2:0]    bank_o;
  logic [RB-1:0] addr_o;

  ddr3_bank_ctrl #(.DDR_ROW_BITS(RB), .DDR_COL_BITS(CB), .ADDR_BITS(AB)) dut (
    .clock(clock), .reset_n(reset_n), .ctl_rdy_i(ctl_rdy_i), .ctl_rfc_i(ctl_rfc_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .request_o(request_o), .command_o(command_o),
    .autopre_o(autopre_o), .accept_i(accept_i), .bank_o(bank_o), .addr_o(addr_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted-command log filled by the monitor.
  int         cyc = 0;
  int         log_n = 0;
  int         rdy_cnt = 0;
  logic [3:0] log_cmd [16];
  logic [2:0] log_bank [16];
  logic [RB-1:0] log_addr [16];
  logic       log_ap [16];
  int         log_cyc [16];

  // Expected command list.
  int         exp_n = 0;
  logic [3:0] exp_cmd [16];
  logic [2:0] exp_bank [16];
  logic [RB-1:0] exp_addr [16];
  logic       exp_ap [16];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset_n) begin
      if (request_o && accept_i && log_n < 16) begin
        log_cmd[log_n]  = command_o;
        log_bank[log_n] = bank_o;
        log_addr[log_n] = addr_o;
        log_ap[log_n]   = autopre_o;
        log_cyc[log_n]  = cyc;
        log_n++;
      end
      if (req_ready_o) rdy_cnt++;
    end
  end

  task automatic begin_scn();
    log_n = 0; rdy_cnt = 0; exp_n = 0;
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [2:0] b,
                          input logic [RB-1:0] a, input logic ap);
    exp_cmd[exp_n] = c; exp_bank[exp_n] = b; exp_addr[exp_n] = a; exp_ap[exp_n] = ap;
    exp_n++;
  endtask

  task automatic compare_log(input string tag, input bit consec);
    check({tag, ".ncmd"}, log_n, exp_n);
    for (int i = 0; i < exp_n && i < log_n; i++) begin
      check($sformatf("%s.cmd%0d", tag, i), log_cmd[i], exp_cmd[i]);
      check($sformatf("%s.bank%0d", tag, i), log_bank[i], exp_bank[i]);
      check($sformatf("%s.addr%0d", tag, i), log_addr[i], exp_addr[i]);
      check($sformatf("%s.ap%0d", tag, i), log_ap[i], exp_ap[i]);
      if (consec && i > 0) check($sformatf("%s.gap%0d", tag, i), log_cyc[i] - log_cyc[i-1], 1);
    end
    check({tag, ".ready_pulses"}, rdy_cnt, 1);
  endtask

  function automatic logic [AB-1:0] mk_addr(input int row, input int bank, input int col);
    logic [RB-1:0] r;
    logic [2:0]    b;
    logic [CB-1:0] c;
    r = RB'(row); b = 3'(bank); c = CB'(col);
    return {r, b, c};
  endfunction

  // Waits (bounded) for the req_ready_o pulse, then drops req_valid_i.
  task automatic wait_ready(input string tag);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (req_ready_o) seen = 1;
    end
    if (!seen) check({tag, ".timeout"}, 0, 1);
    @(posedge clock); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic wr, input int row, input int bank, input int col);
    req_write_i = wr;
    req_addr_i  = mk_addr(row, bank, col);
    req_valid_i = 1'b1;
    wait_ready(tag);
  endtask

  initial begin
    reset_n = 1'b1; ctl_rdy_i = 1'b0; ctl_rfc_i = 1'b0; req_valid_i = 1'b0;
    req_write_i = 1'b0; req_addr_i = '0; accept_i = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst.request", request_o, 0);
    check("rst.ready", req_ready_o, 0);
    check("rst.cmd", command_o, NOOP);
    check("rst.bank", bank_o, 0);
    check("rst.addr", addr_o, 0);
    check("rst.autopre", autopre_o, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Link not ready: request must wait, nothing issued.
    req_valid_i = 1'b1; req_addr_i = mk_addr(5, 2, 'h10);
    repeat (3) begin
      @(negedge clock);
      check("nrdy.request", request_o, 0);
      check("nrdy.ready", req_ready_o, 0);
    end
    @(posedge clock); #1;
    req_valid_i = 1'b0; ctl_rdy_i = 1'b1; accept_i = 1'b1;

    // Closed bank: ACTV then READ.
    begin_scn();
    push_exp(ACTV, 2, 5, 0); push_exp(READ, 2, 'h10, AP);
    do_req("miss", 1'b0, 5, 2, 'h10);
    compare_log("miss", 1);

    // Same row: single WRIT (open page) / ACTV+WRIT (closed page).
    begin_scn();
    if (AP) push_exp(ACTV, 2, 5, 0);
    push_exp(WRIT, 2, 'h20, AP);
    do_req("hit", 1'b1, 5, 2, 'h20);
    compare_log("hit", 1);

    // Different row in open bank: PREC, ACTV, READ.
    begin_scn();
    if (!AP) push_exp(PREC, 2, 0, 0);
    push_exp(ACTV, 2, 9, 0); push_exp(READ, 2, 'h33, AP);
    do_req("conf", 1'b0, 9, 2, 'h33);
    compare_log("conf", 1);

    // Refresh and request together: refresh first, then request from ACTV.
    begin_scn();
    if (!AP) push_exp(PREC, 0, 13'h400, 0);
    push_exp(REFR, 0, 0, 0);
    push_exp(ACTV, 2, 9, 0); push_exp(READ, 2, 'h44, AP);
    ctl_rfc_i = 1'b1;
    req_write_i = 1'b0; req_addr_i = mk_addr(9, 2, 'h44); req_valid_i = 1'b1;
    @(posedge clock); #1 ctl_rfc_i = 1'b0;
    wait_ready("rfc");
    compare_log("rfc", 0);

    // Stall during ACTV for 7 cycles.
    begin_scn();
    push_exp(ACTV, 3, 7, 0); push_exp(READ, 3, 5, AP);
    accept_i = 1'b0;
    req_write_i = 1'b0; req_addr_i = mk_addr(7, 3, 5); req_valid_i = 1'b1;
    @(posedge clock);
    repeat (7) begin
      @(negedge clock);
      check("stall.request", request_o, 1);
      check("stall.cmd", command_o, ACTV);
      check("stall.bank", bank_o, 3);
      check("stall.addr", addr_o, 7);
    end
    @(posedge clock); #1 accept_i = 1'b1;
    wait_ready("stall");
    compare_log("stall", 1);

    // Link drops during ACTV: ACTV completes, then idle until ready again.
    begin_scn();
    push_exp(ACTV, 4, 1, 0); push_exp(READ, 4, 2, AP);
    accept_i = 1'b0;
    req_write_i = 1'b0; req_addr_i = mk_addr(1, 4, 2); req_valid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("drop.cmd", command_o, ACTV);
    @(posedge clock); #1 ctl_rdy_i = 1'b0; accept_i = 1'b1;
    @(posedge clock);
    repeat (3) begin
      @(negedge clock);
      check("drop.idle_request", request_o, 0);
      check("drop.idle_ready", req_ready_o, 0);
    end
    @(posedge clock); #1 ctl_rdy_i = 1'b1;
    wait_ready("drop");
    compare_log("drop", 0);

    // Reset mid-sequence abandons the request without consuming it.
    begin_scn();
    push_exp(ACTV, 5, 2, 0); push_exp(READ, 5, 3, AP);
    accept_i = 1'b0;
    req_write_i = 1'b0; req_addr_i = mk_addr(2, 5, 3); req_valid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mrst.pre_request", request_o, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mrst.request", request_o, 0);
    check("mrst.cmd", command_o, NOOP);
    check("mrst.ready", req_ready_o, 0);
    @(posedge clock); #1 reset_n = 1'b1; accept_i = 1'b1;
    wait_ready("mrst");
    compare_log("mrst", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
